rr_mux_arbiter: RTL
===================

// Module: rr_mux_arbiter
// PURPOSE
// - Round-robin arbiter and sequencer for the one-hot 4:1 select mux (and-or form).
// - Shares one output channel between NUM_REQ requesters.
// - Registers a one-hot grant, muxes the granted requester's data, hands it off with valid/ready.
// - Sits in front of a shared downstream consumer; the grant doubles as the mux select.
// PARAMETERS
// - NUM_REQ  4  number of requesters; grant width; >=2
// - DATA_W   8  payload width per requester
// PORTS
// - clk          in   1               single clock; all state on rising edge
// - reset        in   1               asynchronous, active-high reset
// - req_i        in   NUM_REQ         request per requester; held until ack
// - data_i       in   NUM_REQ*DATA_W  payloads; requester k at [k*DATA_W +: DATA_W]
// - out_ready_i  in   1               downstream ready
// - gnt_o        out  NUM_REQ         registered one-hot grant (mux select); 0 = none
// - out_valid_o  out  1               output valid; equals |gnt_o
// - out_data_o   out  DATA_W          and-or mux of data_i by gnt_o; 0 when gnt_o==0
// - ack_o        out  NUM_REQ         one-hot; gnt_o & {NUM_REQ{out_valid_o & out_ready_i}}
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=IDLE, ptr=0, gnt_o=0.
//   - out_valid_o=0, out_data_o=0, ack_o=0.
// - State IDLE (gnt_o==0):
//   - if |req_i, grant the first requester at or after ptr (circular).
//   - enter BUSY next edge; request-to-grant latency = 1 cycle.
// - State BUSY: gnt_o holds exactly one bit g; out_data_o/out_valid_o are combinational from gnt_o.
// - Transfer = out_valid_o & out_ready_i:
//   - ack_o[g]=1 that cycle.
//   - at the edge: ptr <= (g+1) mod NUM_REQ.
//   - re-arbitrate the same edge from the new ptr over current req_i with req_i[g] masked.
//   - back-to-back grants give zero bubble.
//   - if no other request is pending, go to IDLE.
// - Withdrawal (req_i[g]==0 while BUSY without transfer):
//   - gnt_o <= 0, go to IDLE, ptr unchanged, no ack.
// - Stall (out_ready_i==0): gnt_o, out_data_o stable; new requests do not preempt.
// - Fairness: any continuously requesting input is granted within NUM_REQ transfers.
// - Wrap-around: g=NUM_REQ-1 -> ptr=0.
// - Invariants:
//   - gnt_o is always 0 or one-hot.
//   - ack_o is a subset of gnt_o.
//   - gnt_o never goes to a requester whose req_i was low at the arbitration edge.
// - Reset mid-transfer: outputs clear immediately; the pending beat is lost, with no ack.
// CONFIGURATION
// - ARB_LOCK_EN defined:
//   - adds port lock_i (in, NUM_REQ).
//   - on a transfer with lock_i[g]==1, grant is retained (burst) and ptr is unchanged.
//   - lock_i[g]==0 on a transfer ends the burst with normal rotation.
//   - withdrawal still releases.
// - ARB_LOCK_EN undefined: no lock_i port; grant always released after each transfer.
// TESTING (NUM_REQ=4, DATA_W=8)
// - Reset, req_i=4'b0000:
//   -> gnt_o=0, out_valid_o=0, out_data_o=8'h00.
//   -> assert reset mid-BUSY: outputs 0 asynchronously.
// - req_i=4'b0100, data_i[2]=8'hA5, out_ready_i=1:
//   -> gnt_o=4'b0100 one cycle later, out_data_o=8'hA5, ack_o=4'b0100.
//   -> ptr=3, then IDLE.
// - req_i=4'b1111 held, out_ready_i=1:
//   -> grants 0001,0010,0100,1000,0001 on consecutive cycles, no bubble.
// - Grant 4'b0010, out_ready_i=0 for 5 cycles, req_i[0] rises:
//   -> gnt_o stays 0010, out_data_o stable.
//   -> ready=1 acks 0010, next grant 0001 (wrap via ptr=2..3..0).
// - Grant 4'b1000, drop req_i[3] before ready:
//   -> gnt_o=0 next cycle, no ack_o, ptr unchanged.
// - ARB_LOCK_EN, req_i=4'b0011, lock_i[0]=1 for 3 transfers then 0:
//   -> four acks to 0001, then grant 0010.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bundle for rr_mux_arbiter.
// ARB_LOCK_EN adds the per-requester burst lock.
interface rr_mux_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic                      out_ready_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic                      out_valid_o;
    logic [DATA_W-1:0]         out_data_o;
    logic [NUM_REQ-1:0]        ack_o;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]        lock_i;

    modport master (
        output req_i, data_i, out_ready_i, lock_i,
        input  gnt_o, out_valid_o, out_data_o, ack_o
    );
    modport slave (
        input  req_i, data_i, out_ready_i, lock_i,
        output gnt_o, out_valid_o, out_data_o, ack_o
    );
`else
    modport master (
        output req_i, data_i, out_ready_i,
        input  gnt_o, out_valid_o, out_data_o, ack_o
    );
    modport slave (
        input  req_i, data_i, out_ready_i,
        output gnt_o, out_valid_o, out_data_o, ack_o
    );
`endif
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a one-hot and-or mux onto one valid/ready channel.
// Define ARB_LOCK_EN to let a granted requester hold the channel for bursts.
module rr_mux_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    rr_mux_arbiter_if.slave  bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      g_idx, ptr_nx;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] others;
    logic               valid, xfer, lock_hit;
    logic [DATA_W-1:0]  mux_data;

    // First set bit of r at or after p, wrapping.
    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [PW-1:0]      p
    );
        logic [NUM_REQ-1:0] o;
        logic               done;
        int                 idx;
        o    = '0;
        done = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(p) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!done && r[idx]) begin
                o[idx] = 1'b1;
                done   = 1'b1;
            end
        end
        return o;
    endfunction

    always_comb begin
        g_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_q[k]) g_idx = g_idx | PW'(k);
        end
    end

    assign ptr_nx = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
    assign valid  = |gnt_q;
    assign xfer   = valid & bus.out_ready_i;
    assign others = bus.req_i & ~gnt_q;

`ifdef ARB_LOCK_EN
    assign lock_hit = |(bus.lock_i & gnt_q);
`else
    assign lock_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_i) begin
                    gnt_d   = rr_pick(bus.req_i, ptr_q);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    // Locked beats keep grant and pointer.
                    if (!lock_hit) begin
                        ptr_d   = ptr_nx;
                        gnt_d   = rr_pick(others, ptr_nx);
                        state_d = (|others) ? BUSY : IDLE;
                    end
                end else if (!(|(bus.req_i & gnt_q))) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            mux_data = mux_data |
                (bus.data_i[k*DATA_W +: DATA_W] & {DATA_W{gnt_q[k]}});
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.out_valid_o = valid;
    assign bus.out_data_o  = mux_data;
    assign bus.ack_o       = gnt_q & {NUM_REQ{xfer}};

endmodule
